// File: rtl/mem_stage_mc_if.sv
// Data-memory request/acknowledge bus used by the multi-cycle memory stage.
// The stage is the master; the data memory (or its model) is the slave.
interface mem_stage_mc_if #(
  parameter int DATA_W = 16
);
  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_ack;
  logic [DATA_W-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_stage_mc.sv
// Multi-cycle memory stage: PC-select/forwarding muxes, a req/ack data-memory
// port with timeout, and the MEM/WB pipeline register.
module mem_stage_mc #(
  parameter int DATA_W   = 16,
  parameter int REG_AW   = 3,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        pc_select,
  input  logic [1:0]        fwd_select,
  input  logic [DATA_W-1:0] alu_out_in,
  input  logic [DATA_W-1:0] d2_in,
  input  logic [DATA_W-1:0] pc_plus_1_in,
  input  logic [DATA_W-1:0] pc_plus_imm_in,
  input  logic [DATA_W-1:0] zero_pad_in,
  input  logic [REG_AW-1:0] rd_in,
  output logic              stall_out,
  output logic [DATA_W-1:0] pc_updated_out,
  output logic [DATA_W-1:0] fwd_data_out,
  mem_stage_mc_if.master    dmem,
  output logic              wb_valid,
  output logic              wb_err,
  output logic [DATA_W-1:0] wb_alu_out,
  output logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] wb_pc_plus_1,
  output logic [REG_AW-1:0] wb_rd
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  typedef struct packed {
    logic              rd_op;
    logic              wr_op;
    logic [1:0]        pc_sel;
    logic [1:0]        fwd_sel;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] d2;
    logic [DATA_W-1:0] pcp1;
    logic [DATA_W-1:0] pcimm;
    logic [DATA_W-1:0] zpad;
    logic [REG_AW-1:0] rd;
  } op_t;

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  op_t               op_q;
  logic              wb_valid_q;
  logic              wb_err_q;
  logic [DATA_W-1:0] wb_alu_q;
  logic [DATA_W-1:0] wb_data_q;
  logic [DATA_W-1:0] wb_pcp1_q;
  logic [REG_AW-1:0] wb_rd_q;

  op_t  op_live_d;
  op_t  op_sel_d;
  logic busy_d;
  logic wait_last_d;

  assign busy_d      = (state_q == BUSY);
  assign wait_last_d = (cnt_q == CW'(MAX_WAIT - 1));

  always_comb begin
    op_live_d         = '0;
    op_live_d.rd_op   = mem_read;
    op_live_d.wr_op   = mem_write;
    op_live_d.pc_sel  = pc_select;
    op_live_d.fwd_sel = fwd_select;
    op_live_d.alu     = alu_out_in;
    op_live_d.d2      = d2_in;
    op_live_d.pcp1    = pc_plus_1_in;
    op_live_d.pcimm   = pc_plus_imm_in;
    op_live_d.zpad    = zero_pad_in;
    op_live_d.rd      = rd_in;
  end

  // While a transaction is outstanding the muxes describe the latched op,
  // since upstream may present anything during the stall.
  assign op_sel_d = busy_d ? op_q : op_live_d;

  always_comb begin
    pc_updated_out = '0;
    case (op_sel_d.pc_sel)
      2'b00:   pc_updated_out = op_sel_d.pcp1;
      2'b01:   pc_updated_out = op_sel_d.pcimm;
      2'b10:   pc_updated_out = op_sel_d.d2;
      default: pc_updated_out = '0;
    endcase
  end

  always_comb begin
    fwd_data_out = '0;
    case (op_sel_d.fwd_sel)
      2'b00:   fwd_data_out = op_sel_d.alu;
      2'b01:   fwd_data_out = op_sel_d.pcp1;
      2'b10:   fwd_data_out = op_sel_d.zpad;
      default: fwd_data_out = '0;
    endcase
  end

  assign stall_out       = busy_d;
  assign dmem.dmem_req   = busy_d;
  assign dmem.dmem_we    = busy_d & op_q.wr_op;
  assign dmem.dmem_addr  = busy_d ? op_q.alu : '0;
  assign dmem.dmem_wdata = busy_d ? op_q.d2  : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      wb_valid_q <= 1'b0;
      wb_err_q   <= 1'b0;
      wb_alu_q   <= '0;
      wb_data_q  <= '0;
      wb_pcp1_q  <= '0;
      wb_rd_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && (mem_read || mem_write)) begin
            op_q       <= op_live_d;
            cnt_q      <= '0;
            state_q    <= BUSY;
            wb_valid_q <= 1'b0;
          end else if (in_valid) begin
            wb_valid_q <= 1'b1;
            wb_err_q   <= 1'b0;
            wb_alu_q   <= alu_out_in;
            wb_data_q  <= '0;
            wb_pcp1_q  <= pc_plus_1_in;
            wb_rd_q    <= rd_in;
          end else begin
            wb_valid_q <= 1'b0;
          end
        end
        BUSY: begin
          // An ack on the last allowed cycle still completes cleanly.
          if (dmem.dmem_ack || wait_last_d) begin
            state_q    <= IDLE;
            wb_valid_q <= 1'b1;
            wb_err_q   <= ~dmem.dmem_ack;
            wb_alu_q   <= op_q.alu;
            wb_data_q  <= (dmem.dmem_ack && op_q.rd_op) ? dmem.dmem_rdata : '0;
            wb_pcp1_q  <= op_q.pcp1;
            wb_rd_q    <= op_q.rd;
          end else begin
            cnt_q      <= cnt_q + CW'(1);
            wb_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wb_valid     = wb_valid_q;
  assign wb_err       = wb_err_q;
  assign wb_alu_out   = wb_alu_q;
  assign wb_data      = wb_data_q;
  assign wb_pc_plus_1 = wb_pcp1_q;
  assign wb_rd        = wb_rd_q;

endmodule
